vmem_writer: RTL and testbench

VMEM_WRITER -- requirements
Module: vmem_writer

---
 rtl/vmem_writer.sv | 159 +++++++++++++++
 tb/tb_vmem_writer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_writer.sv
// vmem_writer: turns PLOT / XOR / CLEAR pixel commands into strobes on a
// 1-bit-per-pixel framebuffer port that has a one-cycle read latency.
// PLOT writes in the cycle after acceptance and leaves the block idle. XOR
// does a read-modify-write on the same address. CLEAR sweeps the whole buffer.
module vmem_writer #(
  parameter int W   = 320,
  parameter int HGT = 200,
  parameter int AW  = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [8:0]    cmd_x,
  input  logic [7:0]    cmd_y,
  input  logic          cmd_color,
  output logic          vm_we,
  output logic          vm_re,
  output logic [AW-1:0] vm_addr,
  output logic          vm_wdata,
  input  logic          vm_rdata,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  localparam logic [1:0] OP_PLOT  = 2'd0;
  localparam logic [1:0] OP_XOR   = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(W * HGT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_CLR} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wdata_q, wdata_d;
  logic          color_q, color_d;
  logic [7:0]    drop_q, drop_d;

  logic          accept;
  logic          in_range;
  logic [AW-1:0] cmd_addr;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept   = cmd_valid && cmd_ready;
  assign in_range = (32'(cmd_x) < 32'(W)) && (32'(cmd_y) < 32'(HGT));
  assign cmd_addr = AW'(32'(cmd_y) * 32'(W) + 32'(cmd_x));

  assign vm_we    = we_q;
  assign vm_re    = re_q;
  assign vm_addr  = addr_q;
  assign vm_wdata = wdata_q;
  assign drop_cnt = drop_q;

  // State and registered strobes/datapath; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 1'b0;
      color_q <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      color_q <= color_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: XOR spends RD then two WR cycles (capture, write); CLEAR stays
  // in CLR until the last pixel address is on the bus.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_XOR && in_range) state_d = S_RD;
          else if (cmd_op == OP_CLEAR)      state_d = S_CLR;
        end
      end
      S_RD:  state_d = S_WR;
      S_WR:  if (we_q) state_d = S_IDLE;
      S_CLR: if (addr_q == LAST_ADDR) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and next values of the strobe/address/data registers; address and
  // data hold unless a new access is launched.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !reset;
    busy      = (state_q != S_IDLE);
    we_d      = 1'b0;
    re_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    color_d   = color_q;
    drop_d    = drop_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_PLOT: begin
              if (in_range) begin
                we_d    = 1'b1;
                addr_d  = cmd_addr;
                wdata_d = cmd_color;
              end else begin
                drop_d = sat_inc(drop_q);
              end
            end
            OP_XOR: begin
              if (in_range) begin
                re_d    = 1'b1;
                addr_d  = cmd_addr;
                color_d = cmd_color;
              end else begin
                drop_d = sat_inc(drop_q);
              end
            end
            OP_CLEAR: begin
              we_d    = 1'b1;
              addr_d  = '0;
              wdata_d = cmd_color;
            end
            default: ;
          endcase
        end
      end
      S_RD: ;
      S_WR: begin
        if (!we_q) begin
          we_d    = 1'b1;
          wdata_d = vm_rdata ^ color_q;
        end
      end
      S_CLR: begin
        if (addr_q != LAST_ADDR) begin
          we_d   = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vmem_writer.sv
// tb_vmem_writer: drives vmem_writer against a 1-bit framebuffer model with
// one-cycle read latency and checks strobes, timing and memory contents
// against a command-level reference model.
module tb_vmem_writer;
  localparam int W    = 320;
  localparam int HGT  = 200;
  localparam int AW   = 16;
  localparam int NPIX = W * HGT;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [8:0]    cmd_x = 9'd0;
  logic [7:0]    cmd_y = 8'd0;
  logic          cmd_color = 1'b0;
  logic          vm_we, vm_re, vm_wdata, busy;
  logic [AW-1:0] vm_addr;
  logic          vm_rdata;
  logic [7:0]    drop_cnt;

  vmem_writer #(.W(W), .HGT(HGT), .AW(AW)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .vm_we(vm_we), .vm_re(vm_re), .vm_addr(vm_addr), .vm_wdata(vm_wdata),
    .vm_rdata(vm_rdata), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          d;
  } ev_t;

  bit  ram     [0:65535];
  bit  ref_mem [0:65535];
  ev_t wq[$];
  ev_t rq[$];
  ev_t ew[$];
  ev_t er[$];
  int  exp_drop;
  int  cyc = 0;
  int  busy_total = 0;
  bit  both_seen = 1'b0;
  int  checks = 0;
  int  failures = 0;

  // framebuffer: synchronous write, read data one cycle after vm_re
  always @(posedge clock) begin
    if (vm_we === 1'b1) ram[vm_addr] <= vm_wdata;
    if (vm_re === 1'b1) vm_rdata <= ram[vm_addr];
  end

  always @(posedge clock) cyc <= cyc + 1;

  // record every strobe with the cycle it was visible in
  always @(negedge clock) begin
    if (vm_we === 1'b1) wq.push_back(ev_t'{cyc: cyc, addr: vm_addr, d: vm_wdata});
    if (vm_re === 1'b1) rq.push_back(ev_t'{cyc: cyc, addr: vm_addr, d: 1'b0});
    if (vm_we === 1'b1 && vm_re === 1'b1) both_seen <= 1'b1;
    if (busy === 1'b1) busy_total <= busy_total + 1;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // present one command when the block is ready; returns the accept cycle
  task automatic issue(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y,
                       input logic c, output int acc);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100000) begin step(); n++; end
    if (cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = c;
    acc = cyc;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_x     = 9'($urandom_range(0, 511));
    cmd_y     = 8'($urandom_range(0, 255));
    cmd_color = 1'($urandom_range(0, 1));
  endtask

  // command-level model: expected strobes, memory image and drop count
  task automatic model_cmd(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y,
                           input logic c);
    int a;
    bit ok;
    ok = (int'(x) < W) && (int'(y) < HGT);
    a  = int'(y) * W + int'(x);
    if (op == 2'd0 || op == 2'd1) begin
      if (!ok) begin
        if (exp_drop < 255) exp_drop++;
      end else if (op == 2'd0) begin
        ref_mem[a] = c;
        ew.push_back(ev_t'{cyc: 0, addr: AW'(a), d: c});
      end else begin
        er.push_back(ev_t'{cyc: 0, addr: AW'(a), d: 1'b0});
        ref_mem[a] = ref_mem[a] ^ c;
        ew.push_back(ev_t'{cyc: 0, addr: AW'(a), d: ref_mem[a]});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0;
    repeat (3) step();
    checks++; if (vm_we !== 1'b0) begin failures++; $display("FAIL rst_vm_we: got %b want 0", vm_we); end
    checks++; if (vm_re !== 1'b0) begin failures++; $display("FAIL rst_vm_re: got %b want 0", vm_re); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (vm_addr !== 16'd0) begin failures++; $display("FAIL rst_vm_addr: got %0d want 0", vm_addr); end
    checks++; if (vm_wdata !== 1'b0) begin failures++; $display("FAIL rst_vm_wdata: got %b want 0", vm_wdata); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    // a command offered on the last reset cycle must be ignored
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_x = 9'd3; cmd_y = 8'd0; cmd_color = 1'b1;
    step();
    reset = 1'b0; cmd_valid = 1'b0;
    repeat (3) step();
    checks++; if (wq.size() != 0 || rq.size() != 0) begin
      failures++; $display("FAIL rst_release_cmd: got writes=%0d reads=%0d want 0/0", wq.size(), rq.size());
    end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after: got %b want 1", cmd_ready); end
  endtask

  task automatic test_plot_corner();
    int acc;
    wq.delete();
    issue(2'd0, 9'd319, 8'd199, 1'b1, acc);
    ref_mem[63999] = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL plot_ready: got %b want 1", cmd_ready); end
    checks++;
    if (wq.size() != 1) begin
      failures++; $display("FAIL plot_corner_count: got %0d want 1", wq.size());
    end else if (wq[0].cyc != acc + 1 || wq[0].addr !== 16'd63999 || wq[0].d !== 1'b1) begin
      failures++; $display("FAIL plot_corner: got cyc=%0d addr=%0d d=%b want cyc=%0d addr=63999 d=1",
                           wq[0].cyc, wq[0].addr, wq[0].d, acc + 1);
    end
  endtask

  task automatic test_back_to_back();
    int acc0, acc;
    int   ea [4] = '{0, 1, 320, 645};
    logic [8:0] xs [4] = '{9'd0, 9'd1, 9'd0, 9'd5};
    logic [7:0] ys [4] = '{8'd0, 8'd0, 8'd1, 8'd2};
    logic cs [4];
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      cs[i] = 1'($urandom_range(0, 1));
      issue(2'd0, xs[i], ys[i], cs[i], acc);
      if (i == 0) acc0 = acc;
      ref_mem[ea[i]] = cs[i];
    end
    step();
    checks++;
    if (wq.size() != 4) begin
      failures++; $display("FAIL b2b_count: got %0d want 4", wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq[i].cyc != acc0 + 1 + i || int'(wq[i].addr) != ea[i] || wq[i].d !== cs[i]) begin
          failures++; $display("FAIL b2b_write%0d: got cyc=%0d addr=%0d d=%b want cyc=%0d addr=%0d d=%b",
                               i, wq[i].cyc, wq[i].addr, wq[i].d, acc0 + 1 + i, ea[i], cs[i]);
        end
      end
    end
  endtask

  task automatic test_xor();
    int acc;
    issue(2'd0, 9'd10, 8'd0, 1'b1, acc);
    ref_mem[10] = 1'b1;
    repeat (2) step();
    wq.delete(); rq.delete();
    issue(2'd1, 9'd10, 8'd0, 1'b1, acc);
    ref_mem[10] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL xor_ready_n%0d: got %b want 0", k, cmd_ready); end
      step();
    end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL xor_ready_after: got %b want 1", cmd_ready); end
    checks++;
    if (rq.size() != 1 || rq[0].cyc != acc + 1 || rq[0].addr !== 16'd10) begin
      failures++; $display("FAIL xor_read: got count=%0d want one read at cyc %0d addr 10", rq.size(), acc + 1);
    end
    checks++;
    if (wq.size() != 1 || wq[0].cyc != acc + 3 || wq[0].addr !== 16'd10 || wq[0].d !== 1'b0) begin
      failures++; $display("FAIL xor_write: got count=%0d want one write at cyc %0d addr 10 d 0", wq.size(), acc + 3);
    end
  endtask

  task automatic test_op3();
    int acc;
    logic [7:0] d0;
    d0 = drop_cnt;
    wq.delete(); rq.delete();
    issue(2'd3, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 1'b1, acc);
    issue(2'd0, 9'd2, 8'd0, 1'b1, acc);
    ref_mem[2] = 1'b1;
    repeat (3) step();
    checks++;
    if (wq.size() != 1 || rq.size() != 0) begin
      failures++; $display("FAIL op3_strobes: got writes=%0d reads=%0d want 1/0", wq.size(), rq.size());
    end else if (wq[0].addr !== 16'd2) begin
      failures++; $display("FAIL op3_strobes: got addr=%0d want 2", wq[0].addr);
    end
    checks++; if (drop_cnt !== d0) begin failures++; $display("FAIL op3_drop: got %0d want %0d", drop_cnt, d0); end
  endtask

  task automatic test_drop();
    int acc;
    logic [8:0] x;
    logic [7:0] y;
    wq.delete(); rq.delete();
    issue(2'd0, 9'd320, 8'd5, 1'b1, acc);
    issue(2'd0, 9'd5, 8'd200, 1'b1, acc);
    repeat (3) step();
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL drop_two: got %0d want 2", drop_cnt); end
    for (int i = 0; i < 298; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        x = 9'($urandom_range(320, 511)); y = 8'($urandom_range(0, 255));
      end else begin
        x = 9'($urandom_range(0, 511));   y = 8'($urandom_range(200, 255));
      end
      issue(2'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 1)), acc);
    end
    repeat (3) step();
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat: got %0d want 255", drop_cnt); end
    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      failures++; $display("FAIL drop_strobes: got writes=%0d reads=%0d want 0/0", wq.size(), rq.size());
    end
  endtask

  task automatic test_clear_full();
    int acc, n, b0, errs;
    wq.delete();
    b0 = busy_total;
    issue(2'd2, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 1'b0, acc);
    n = 0;
    while (busy === 1'b1 && n < 70000) begin step(); n++; end
    for (int i = 0; i < NPIX; i++) ref_mem[i] = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_timeout: busy=%b want 0", busy); end
    checks++; if (busy_total - b0 != NPIX) begin failures++; $display("FAIL clear_busy: got %0d want %0d", busy_total - b0, NPIX); end
    checks++; if (wq.size() != NPIX) begin failures++; $display("FAIL clear_count: got %0d want %0d", wq.size(), NPIX); end
    errs = 0;
    for (int i = 0; i < wq.size() && i < NPIX; i++)
      if (int'(wq[i].addr) != i || wq[i].d !== 1'b0 || wq[i].cyc != acc + 1 + i) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL clear_sequence: got %0d bad writes want 0", errs); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL clear_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_clear_abort();
    int acc, n;
    wq.delete();
    issue(2'd2, 9'd0, 8'd0, 1'b1, acc);
    n = 0;
    while (wq.size() < 100 && n < 1000) begin step(); n++; end
    reset = 1'b1;
    step();
    checks++; if (vm_we !== 1'b0) begin failures++; $display("FAIL abort_we: got %b want 0", vm_we); end
    step();
    reset = 1'b0;
    step();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
    repeat (3) step();
    for (int i = 0; i < 100; i++) ref_mem[i] = 1'b1;
    checks++;
    if (wq.size() != 100 || wq[wq.size()-1].addr !== 16'd99) begin
      failures++; $display("FAIL abort_writes: got %0d writes want 100 ending at 99", wq.size());
    end
    checks++; if (drop_cnt !== 8'd0 || vm_addr !== 16'd0) begin
      failures++; $display("FAIL abort_regs: got drop=%0d addr=%0d want 0/0", drop_cnt, vm_addr);
    end
    checks++; if (ram[99] !== 1'b1 || ram[100] !== 1'b0) begin
      failures++; $display("FAIL abort_mem: got ram99=%b ram100=%b want 1/0", ram[99], ram[100]);
    end
  endtask

  task automatic test_random();
    int acc, errs, n;
    logic [1:0] op;
    logic [8:0] x;
    logic [7:0] y;
    logic c;
    wq.delete(); rq.delete(); ew.delete(); er.delete();
    exp_drop = 0;
    for (int i = 0; i < 300; i++) begin
      n  = $urandom_range(0, 9);
      op = (n < 4) ? 2'd0 : (n < 8) ? 2'd1 : 2'd3;
      x  = 9'($urandom_range(0, 335));
      y  = 8'($urandom_range(0, 207));
      c  = 1'($urandom_range(0, 1));
      model_cmd(op, x, y, c);
      issue(op, x, y, c, acc);
      if (i % 25 == 0) begin
        // write immediately followed by a read-modify-write of the same pixel
        model_cmd(2'd0, 9'd7, 8'd3, 1'b1);
        issue(2'd0, 9'd7, 8'd3, 1'b1, acc);
        model_cmd(2'd1, 9'd7, 8'd3, 1'b1);
        issue(2'd1, 9'd7, 8'd3, 1'b1, acc);
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 10) begin step(); n++; end
    repeat (3) step();
    checks++; if (wq.size() != ew.size()) begin failures++; $display("FAIL rand_wcount: got %0d want %0d", wq.size(), ew.size()); end
    checks++; if (rq.size() != er.size()) begin failures++; $display("FAIL rand_rcount: got %0d want %0d", rq.size(), er.size()); end
    errs = 0;
    for (int i = 0; i < wq.size() && i < ew.size(); i++)
      if (wq[i].addr !== ew[i].addr || wq[i].d !== ew[i].d) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL rand_writes: got %0d differing writes want 0", errs); end
    errs = 0;
    for (int i = 0; i < rq.size() && i < er.size(); i++)
      if (rq[i].addr !== er[i].addr) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL rand_reads: got %0d differing reads want 0", errs); end
    checks++; if (int'(drop_cnt) != exp_drop) begin failures++; $display("FAIL rand_drop: got %0d want %0d", drop_cnt, exp_drop); end
    errs = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] != ref_mem[i]) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL rand_image: got %0d differing pixels want 0", errs); end
  endtask

  task automatic test_strobes();
    checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL strobe_overlap: got %b want 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_plot_corner();
    test_back_to_back();
    test_xor();
    test_op3();
    test_drop();
    test_clear_full();
    test_clear_abort();
    test_random();
    test_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
